sw_seq_sched: RTL

//  Step scheduler for the DAC switch driver. On each trigger it plays a programmed list of switch-timing steps.

---
 rtl/sw_seq_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sw_seq_sched.sv
// Step scheduler for the DAC switch driver: per trigger, plays a table of 24x14-bit switch-time groups.
// Latency: trig to first sw_req rise is 1+24+REQ_LOW cycles; each step then waits on sw_ack or timeout.
// Backpressure: one sw_req/sw_ack handshake per step; trig while busy is dropped and flagged in trig_overrun_o.
`timescale 1ns/1ps
module sw_seq_sched #(
  parameter int MAX_STEPS = 8,
  parameter int REQ_HIGH  = 4,
  parameter int REQ_LOW   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tbl_wr_en_i,
  input  logic [$clog2(MAX_STEPS)+4:0] tbl_wr_addr_i,
  input  logic [13:0]                  tbl_wr_data_i,
  input  logic [$clog2(MAX_STEPS):0]   cfg_num_steps_i,
  input  logic [31:0]                  cfg_timeout_i,
  input  logic                         trig_i,
  input  logic                         abort_i,
  output logic [335:0]                 sw_time_group_o,
  output logic                         sw_req_o,
  input  logic                         sw_ack_i,
  output logic                         busy_o,
  output logic [$clog2(MAX_STEPS)-1:0] step_idx_o,
  output logic                         seq_done_o,
  output logic                         err_timeout_o,
  output logic                         trig_overrun_o
);
  localparam int SW   = $clog2(MAX_STEPS);
  localparam int NCH  = 24;
  localparam int CHW  = 14;
  localparam int CMAX = (REQ_LOW > REQ_HIGH) ? ((REQ_LOW > NCH) ? REQ_LOW : NCH)
                                             : ((REQ_HIGH > NCH) ? REQ_HIGH : NCH);
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_REQ, S_WAIT, S_NEXT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          step_q, step_d;
  logic [SW:0]            num_q, num_d;
  logic [31:0]            tcfg_q, tcfg_d;
  logic [31:0]            tmo_q, tmo_d;
  logic                   ack_seen_q, ack_seen_d;
  logic                   err_q, err_d;
  logic                   ovr_q, ovr_d;
  logic                   req_q, busy_q, done_q;
  logic                   seq_done_d;
  logic                   last_step;
  logic [SW:0]            num_clamped;

  logic [CHW-1:0]         tbl_q [MAX_STEPS][NCH];
  logic [SW-1:0]          wr_step;
  logic [4:0]             wr_chan;
  logic [4:0]             ld_chan;
  logic [CHW-1:0]         rd_dat;
  logic [(NCH-1)*CHW-1:0] shadow_q;
  logic [NCH*CHW-1:0]     group_q;

  assign wr_step = tbl_wr_addr_i[SW+4:5];
  assign wr_chan = tbl_wr_addr_i[4:0];
  assign ld_chan = cnt_q[4:0];
  // Combinational read returns the pre-write value when a same-entry write lands in the same cycle.
  assign rd_dat  = tbl_q[step_q][ld_chan];

  assign num_clamped = (cfg_num_steps_i > (SW+1)'(MAX_STEPS)) ? (SW+1)'(MAX_STEPS) : cfg_num_steps_i;
  assign last_step   = ({1'b0, step_q} == (num_q - (SW+1)'(1)));

  // Step table: plain flops, no reset, channels 24..31 of each step are not stored.
  always_ff @(posedge clk) begin
    if (tbl_wr_en_i && (wr_chan < 5'(NCH))) begin
      tbl_q[wr_step][wr_chan] <= tbl_wr_data_i;
    end
  end

  // Shadow fill one channel per LOAD cycle; the visible group is published together with the last channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      group_q  <= '0;
    end else if ((state_q == S_LOAD) && !abort_i) begin
      if (ld_chan != 5'(NCH-1)) begin
        shadow_q[ld_chan*CHW +: CHW] <= rd_dat;
      end else begin
        group_q <= {rd_dat, shadow_q};
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      num_q      <= '0;
      tcfg_q     <= '0;
      tmo_q      <= '0;
      ack_seen_q <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      num_q      <= num_d;
      tcfg_q     <= tcfg_d;
      tmo_q      <= tmo_d;
      ack_seen_q <= ack_seen_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      req_q      <= (state_d == S_REQ);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= seq_done_d;
    end
  end

  // Next-state: step sequencing, handshake timing, saturating ack timeout, abort override.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    num_d      = num_q;
    tcfg_d     = tcfg_q;
    tmo_d      = (tmo_q != '1) ? (tmo_q + 32'd1) : tmo_q;
    ack_seen_d = ack_seen_q;
    err_d      = err_q;
    ovr_d      = ovr_q;
    seq_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_i && !abort_i && (cfg_num_steps_i != '0)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          step_d  = '0;
          num_d   = num_clamped;
          tcfg_d  = cfg_timeout_i;
          err_d   = 1'b0;
          ovr_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (cnt_q == CW'(NCH-1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(REQ_LOW-1)) begin
          state_d    = S_REQ;
          cnt_d      = '0;
          tmo_d      = '0;
          ack_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REQ: begin
        if (sw_ack_i) ack_seen_d = 1'b1;
        if (cnt_q == CW'(REQ_HIGH-1)) begin
          cnt_d   = '0;
          state_d = (ack_seen_q || sw_ack_i) ? S_NEXT : S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (sw_ack_i) begin
          state_d = S_NEXT;
        end else if ((tcfg_q != '0) && (tmo_q >= (tcfg_q - 32'd1))) begin
          err_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_step) begin
          state_d = S_IDLE;
        end else begin
          step_d  = step_q + SW'(1);
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (trig_i && (state_q != S_IDLE)) ovr_d = 1'b1;
    if (abort_i) state_d = S_IDLE;
    seq_done_d = (state_d == S_NEXT) && last_step;
  end

  assign sw_time_group_o = group_q;
  assign sw_req_o        = req_q;
  assign busy_o          = busy_q;
  assign step_idx_o      = step_q;
  assign seq_done_o      = done_q;
  assign err_timeout_o   = err_q;
  assign trig_overrun_o  = ovr_q;
endmodule
